// File: rtl/dmem_pkg.sv
// Shared definitions for the MIPS data-memory responder.
//   - dmem_state_e : responder FSM states (IDLE, WAIT, RESP)
//   - WORD_W/BE_W  : data word and byte-enable widths
//   - BE_*         : legal byte-enable patterns. The core's store path uses
//                    them too, so both ends agree on the lane layout.
//   - be_legal()   : is a byte-enable pattern consistent with a byte offset?
//   - dmem_req_t   : request fields captured when a request is accepted
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam logic [BE_W-1:0] BE_NONE    = 4'b0000;
  localparam logic [BE_W-1:0] BE_BYTE0   = 4'b0001;
  localparam logic [BE_W-1:0] BE_BYTE1   = 4'b0010;
  localparam logic [BE_W-1:0] BE_BYTE2   = 4'b0100;
  localparam logic [BE_W-1:0] BE_BYTE3   = 4'b1000;
  localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } dmem_req_t;

  // Byte offset must match the lane group: a byte lands on its own lane,
  // a half-word on an even offset matching its half, and a full word (or an
  // empty mask) must be word aligned. Any other pattern is illegal.
  function automatic logic be_legal(input logic [BE_W-1:0] be,
                                    input logic [1:0]      off);
    logic ok;
    ok = 1'b0;
    case (be)
      BE_NONE, BE_WORD, BE_HALF_LO, BE_BYTE0: ok = (off == 2'd0);
      BE_BYTE1:                               ok = (off == 2'd1);
      BE_HALF_HI, BE_BYTE2:                   ok = (off == 2'd2);
      BE_BYTE3:                               ok = (off == 2'd3);
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM, 2**ADDR_W x 32, organised as four
// independent byte lanes so it can later be swapped for an SRAM macro with
// per-byte write enables.
//   clk   : rising-edge clock
//   addr  : word index
//   wdata : write data
//   wbe   : per-byte write enable (bit i writes wdata[8i+7:8i])
//   rdata : registered read data (old contents on a write cycle)
// No reset: storage contents survive a responder reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   wbe,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (wbe[i]) mem[addr] <= wdata[8*i +: 8];
      q <= mem[addr];
    end

    assign rdata[8*i +: 8] = q;
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the MIPS core's load/store port.
// Accepts a request in IDLE, waits WAIT_STATES cycles, then pulses ack for
// one cycle (RESP) with rdata/err. Stores commit at the edge leaving RESP.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request strobe, only looked at in IDLE
//   we         : 1 = store, 0 = load
//   addr       : byte address
//   wdata, be  : store data and byte enables (be[0] = bits 7:0)
//   rdata      : load data, nonzero only while ack=1 on a good load
//   ack        : one-cycle response strobe
//   err        : out-of-range or misaligned access, valid with ack
//   busy       : high in any state other than IDLE
// Build option DMEM_BYTE_LANE_EN: honour be on stores and relax alignment to
// the byte/half-word patterns in dmem_pkg. Without it, be is ignored, every
// store writes the full word and any nonzero addr[1:0] is an error.
module mips_dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  localparam int          CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  dmem_state_e       state;
  logic [CNT_W-1:0]  cnt;
  dmem_req_t         lat;
  logic [ADDR_W-1:0] lat_idx;
  logic              lat_err;

  // ---------------------------------------------------------------------
  // Request decode on the live inputs; the result is captured at accept.
  // ---------------------------------------------------------------------
  logic            oor;
  logic            misalign;
  logic            req_err;
  logic [BE_W-1:0] req_be;

  assign oor = |addr[WORD_W-1:ADDR_W+2];

`ifdef DMEM_BYTE_LANE_EN
  assign misalign = !be_legal(be, addr[1:0]);
  assign req_be   = be;
`else
  logic unused_be;
  assign unused_be = ^be;
  assign misalign  = |addr[1:0];
  assign req_be    = BE_WORD;
`endif

  assign req_err = oor | misalign;

  // ---------------------------------------------------------------------
  // Storage. The read port follows the live address while IDLE so that a
  // zero-wait request has its data ready on entering RESP; otherwise it
  // tracks the latched index. The write happens only in RESP, so it lands
  // on the RESP-exit edge and an aborted transaction never writes.
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] ram_idx;
  logic [BE_W-1:0]   ram_wbe;
  logic [WORD_W-1:0] ram_q;

  assign ram_idx = (state == IDLE) ? addr[ADDR_W+1:2] : lat_idx;
  assign ram_wbe = (state == RESP && lat.we && !lat_err) ? lat.be : '0;

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .addr  (ram_idx),
    .wdata (lat.wdata),
    .wbe   (ram_wbe),
    .rdata (ram_q)
  );

  // ---------------------------------------------------------------------
  // FSM with registered ack/err/busy.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      lat     <= '0;
      lat_idx <= '0;
      lat_err <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lat.we    <= we;
            lat.wdata <= wdata;
            lat.be    <= req_be;
            lat_idx   <= addr[ADDR_W+1:2];
            lat_err   <= req_err;
            busy      <= 1'b1;
            if (WAIT_STATES == 0) begin
              state <= RESP;
              ack   <= 1'b1;
              err   <= req_err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            ack   <= 1'b1;
            err   <= lat_err;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Load data is only exposed on a clean load response.
  assign rdata = (ack && !lat.we && !err) ? ram_q : '0;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench: u0 runs with WAIT_STATES=2, u1 with WAIT_STATES=0.
// Stimulus pushes the expected response (ack cycle, err, rdata) into a
// per-instance queue; a monitor pops and compares on every ack.
module tb_mips_dmem_responder;
  import dmem_pkg::*;

  localparam int WS0 = 2;
  localparam int WS1 = 0;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [3:0]  be0 = 4'hF;
  logic [31:0] rdata0;
  logic        ack0, err0, busy0;
  logic        req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic [3:0]  be1 = 4'hF;
  logic [31:0] rdata1;
  logic        ack1, err1, busy1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_dmem_responder #(.ADDR_W(10), .WAIT_STATES(WS0)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .addr(addr0),
    .wdata(wdata0), .be(be0), .rdata(rdata0), .ack(ack0), .err(err0),
    .busy(busy0)
  );

  mips_dmem_responder #(.ADDR_W(10), .WAIT_STATES(WS1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .we(we1), .addr(addr1),
    .wdata(wdata1), .be(be1), .rdata(rdata1), .ack(ack1), .err(err1),
    .busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ack0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0_spurious_ack: got ack=1 expected no ack (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        chk("u0_ack_cycle", cyc, e.cyc);
        chk("u0_err", {31'd0, err0}, {31'd0, e.err});
        chk("u0_rdata", rdata0, e.rdata);
      end
    end else if (rst_n) begin
      chk("u0_rdata_no_ack", rdata0, 32'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ack1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1_spurious_ack: got ack=1 expected no ack (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        chk("u1_ack_cycle", cyc, e.cyc);
        chk("u1_err", {31'd0, err1}, {31'd0, e.err});
        chk("u1_rdata", rdata1, e.rdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge with u0 idle; returns at a negedge with u0 idle.
  task automatic xfer0(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic e_err, input logic [31:0] e_rd,
                       input bit inject);
    exp_t e;
    e.cyc = cyc + 1 + WS0;
    e.err = e_err;
    e.rdata = e_rd;
    q0.push_back(e);
    req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; be0 = b;
    @(negedge clk);
    // Scramble the inputs after acceptance; they must have no effect.
    req0 = 1'b0; we0 = ~w; addr0 = 32'hFFFF_FFFC; wdata0 = 32'h5A5A_5A5A;
    for (int i = 0; i <= WS0; i++) begin
      chk("u0_busy", {31'd0, busy0}, 32'd1);
      if (inject && i == 0) begin
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hFFFF_FFFF;
        be0 = 4'hF;
      end else begin
        req0 = 1'b0;
      end
      @(negedge clk);
    end
    chk("u0_busy_idle", {31'd0, busy0}, 32'd0);
  endtask

  task automatic step1(input logic w, input logic [31:0] d,
                       input logic [31:0] e_rd);
    exp_t e;
    e.cyc = cyc + 1;
    e.err = 1'b0;
    e.rdata = e_rd;
    q1.push_back(e);
    req1 = 1'b1; we1 = w; addr1 = 32'h40; wdata1 = d; be1 = 4'hF;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ack0", {31'd0, ack0}, 32'd0);
    chk("rst_err0", {31'd0, err0}, 32'd0);
    chk("rst_busy0", {31'd0, busy0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_ack1", {31'd0, ack1}, 32'd0);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Store then load, plus misaligned / out-of-range accesses.
    xfer0(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 1'b0);
    xfer0(1'b0, 32'h10, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF, 1'b0);
    xfer0(1'b1, 32'h12, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h0, 1'b0);
    xfer0(1'b0, 32'h10, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF, 1'b0);
    xfer0(1'b0, 32'h1000, 32'h0,       4'hF, 1'b1, 32'h0, 1'b0);
    xfer0(1'b0, 32'h8000_0010, 32'h0,  4'hF, 1'b1, 32'h0, 1'b0);
    // Top in-range word.
    xfer0(1'b1, 32'hFFC, 32'h1357_9BDF, 4'hF, 1'b0, 32'h0, 1'b0);
    xfer0(1'b0, 32'hFFC, 32'h0,         4'hF, 1'b0, 32'h1357_9BDF, 1'b0);

    // A store to 0x20 attempted while busy must be dropped.
    xfer0(1'b1, 32'h20, 32'h1111_2222, 4'hF, 1'b0, 32'h0, 1'b0);
    xfer0(1'b0, 32'h10, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF, 1'b1);
    xfer0(1'b0, 32'h20, 32'h0,         4'hF, 1'b0, 32'h1111_2222, 1'b0);

    // Reset in the middle of a store: no ack, no write.
    xfer0(1'b1, 32'h30, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0, 1'b0);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h30; wdata0 = 32'h1234_5678; be0 = 4'hF;
    @(negedge clk);
    req0 = 1'b0;
    chk("mid_busy_before_rst", {31'd0, busy0}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy0}, 32'd0);
    chk("mid_rst_ack", {31'd0, ack0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    xfer0(1'b0, 32'h30, 32'h0, 4'hF, 1'b0, 32'h0BAD_F00D, 1'b0);

    // Byte lanes.
    xfer0(1'b1, 32'h50, 32'hAABB_CCDD, 4'hF, 1'b0, 32'h0, 1'b0);
`ifdef DMEM_BYTE_LANE_EN
    xfer0(1'b1, 32'h51, 32'h0000_1100, 4'b0010, 1'b0, 32'h0, 1'b0);
    xfer0(1'b0, 32'h50, 32'h0,         4'hF,    1'b0, 32'hAABB_11DD, 1'b0);
    xfer0(1'b1, 32'h51, 32'h0000_7777, 4'b0011, 1'b1, 32'h0, 1'b0);
    xfer0(1'b1, 32'h52, 32'h9988_0000, 4'b1100, 1'b0, 32'h0, 1'b0);
    xfer0(1'b1, 32'h50, 32'h0102_0304, 4'b0000, 1'b0, 32'h0, 1'b0);
    xfer0(1'b0, 32'h50, 32'h0,         4'hF,    1'b0, 32'h9988_11DD, 1'b0);
`else
    xfer0(1'b1, 32'h51, 32'h0000_1100, 4'b0010, 1'b1, 32'h0, 1'b0);
    xfer0(1'b0, 32'h50, 32'h0,         4'hF,    1'b0, 32'hAABB_CCDD, 1'b0);
    xfer0(1'b1, 32'h54, 32'h0102_0304, 4'b0000, 1'b0, 32'h0, 1'b0);
    xfer0(1'b0, 32'h54, 32'h0,         4'hF,    1'b0, 32'h0102_0304, 1'b0);
`endif

    // Zero wait states, req held high: one transaction every two cycles.
    step1(1'b1, 32'hA5A5_0001, 32'h0);
    step1(1'b0, 32'h0,         32'hA5A5_0001);
    step1(1'b1, 32'h5A5A_0002, 32'h0);
    step1(1'b0, 32'h0,         32'h5A5A_0002);
    req1 = 1'b0;
    repeat (4) @(negedge clk);

    chk("u0_pending", q0.size(), 32'd0);
    chk("u1_pending", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
